// File: rtl/pmc_dc_init_pkg.sv
// Shared types and constants for the PMC digital-config bus initiator.
package pmc_dc_init_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_REQ = 3'd1,
    ST_WR_RSP = 3'd2,
    ST_RD_REQ = 3'd3,
    ST_RD_RSP = 3'd4,
    ST_FINISH = 3'd5
  } pmc_dc_init_state_t;

  localparam logic [3:0] PMC_DC_INIT_BE_ALL = 4'hF;

  // Attempts can reach 8 with the largest retry setting; the 3-bit report saturates.
  function automatic logic [2:0] sat_attempts(input logic [3:0] cnt);
    logic [2:0] res;
    if (cnt > 4'd7) begin
      res = 3'd7;
    end else begin
      res = cnt[2:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/pmc_dc_pkg.sv
// Register map of the PMC digital-config slave, shared with every initiator
// that programs it.
package pmc_dc_pkg;

  localparam logic [31:0] PMC_DC_REG_0 = 32'h0000_0000;

endpackage

// File: rtl/pmc_dc_init_if.sv
// Ibex-style data bus: one request/grant channel plus a response channel.
interface ibex_data_bus;

  logic        req;
  logic        gnt;
  logic        rvalid;
  logic        we;
  logic        err;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/pmc_dc_init_timer.sv
// Clearable saturating 16-bit down-counter; expired is high while the count is zero.
module pmc_dc_init_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] load_val,
  output logic        expired
);

  logic [15:0] cnt_r;

  // Reload on request, otherwise count down and stick at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 16'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != 16'd0)) begin
      cnt_r <= cnt_r - 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == 16'd0);

endmodule

// File: rtl/pmc_dc_init.sv
// Boot-time initiator: writes the PMC digital-config word, reads it back,
// retries on mismatch or bus error and reports pass/fail.
module pmc_dc_init
  import pmc_dc_init_pkg::*;
  import pmc_dc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = PMC_DC_REG_0,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  ibex_data_bus.master       data_bus,
  input  logic               start,
  input  logic [31:0]        cfg_wdata,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [31:0]        readback,
  output logic [2:0]         attempts
);

  localparam logic [2:0]  S_IDLE       = ST_IDLE;
  localparam logic [2:0]  S_WR_REQ     = ST_WR_REQ;
  localparam logic [2:0]  S_WR_RSP     = ST_WR_RSP;
  localparam logic [2:0]  S_RD_REQ     = ST_RD_REQ;
  localparam logic [2:0]  S_RD_RSP     = ST_RD_RSP;
  localparam logic [2:0]  S_FINISH     = ST_FINISH;
  localparam logic [3:0]  LAST_ATTEMPT = 4'(MAX_RETRIES + 1);
  // Loaded on state entry so the counter hits zero in the TIMEOUT_CYCLES-th cycle.
  localparam logic [15:0] TMO_LOAD     = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_r, state_nxt_s;
  logic [3:0]  attempt_cnt_r;
  logic [31:0] word_r;
  logic        req_r, we_r, busy_r, done_r, fail_r;
  logic [3:0]  be_r;
  logic [31:0] addr_r, readback_r;
  logic [2:0]  attempts_r;
  logic        fail_s, retry_s, bad_s, accept_s, issue_s, active_s;
  logic        tmo_load_s, tmo_expired_s;

  pmc_dc_init_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmo_load_s),
    .en       (active_s),
    .load_val (TMO_LOAD),
    .expired  (tmo_expired_s)
  );

  // Next-state decode; gnt/rvalid take priority over an expiring timeout.
  always_comb begin
    state_nxt_s = state_r;
    fail_s      = 1'b0;
    retry_s     = 1'b0;
    bad_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_WR_REQ;
        else       state_nxt_s = S_IDLE;
      end
      S_WR_REQ, S_RD_REQ: begin
        if (data_bus.gnt) begin
          state_nxt_s = (state_r == S_WR_REQ) ? S_WR_RSP : S_RD_RSP;
        end else if (tmo_expired_s) begin
          state_nxt_s = S_FINISH;
          fail_s      = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_WR_RSP: begin
        if (data_bus.rvalid) begin
          if (data_bus.err) bad_s = 1'b1;
          else              state_nxt_s = S_RD_REQ;
        end else if (tmo_expired_s) begin
          state_nxt_s = S_FINISH;
          fail_s      = 1'b1;
        end else begin
          state_nxt_s = S_WR_RSP;
        end
      end
      S_RD_RSP: begin
        if (data_bus.rvalid) begin
          if (!data_bus.err && (data_bus.rdata == word_r)) state_nxt_s = S_FINISH;
          else                                              bad_s = 1'b1;
        end else if (tmo_expired_s) begin
          state_nxt_s = S_FINISH;
          fail_s      = 1'b1;
        end else begin
          state_nxt_s = S_RD_RSP;
        end
      end
      S_FINISH: state_nxt_s = S_IDLE;
      default:  state_nxt_s = S_IDLE;
    endcase
    if (bad_s) begin
      if (attempt_cnt_r < LAST_ATTEMPT) begin
        state_nxt_s = S_WR_REQ;
        retry_s     = 1'b1;
      end else begin
        state_nxt_s = S_FINISH;
        fail_s      = 1'b1;
      end
    end else begin
      retry_s = 1'b0;
    end
  end

  assign accept_s   = (state_r == S_IDLE) && start;
  assign issue_s    = (state_nxt_s == S_WR_REQ) || (state_nxt_s == S_RD_REQ);
  assign active_s   = (state_r == S_WR_REQ) || (state_r == S_WR_RSP) ||
                      (state_r == S_RD_REQ) || (state_r == S_RD_RSP);
  assign tmo_load_s = (state_nxt_s != state_r);

  // Sequencer state, attempt counter and latched config word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      attempt_cnt_r <= 4'd0;
      word_r        <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        attempt_cnt_r <= 4'd1;
        word_r        <= cfg_wdata;
      end else if (retry_s) begin
        attempt_cnt_r <= attempt_cnt_r + 4'd1;
      end
    end
  end

  // Bus request signals, registered from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r  <= 1'b0;
      we_r   <= 1'b0;
      be_r   <= 4'h0;
      addr_r <= 32'h0000_0000;
    end else begin
      req_r <= issue_s;
      we_r  <= (state_nxt_s == S_WR_REQ);
      be_r  <= issue_s ? PMC_DC_INIT_BE_ALL : 4'h0;
      if (issue_s) addr_r <= BASE_ADDR;
    end
  end

  // Status outputs and read-back capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      fail_r     <= 1'b0;
      readback_r <= 32'h0000_0000;
      attempts_r <= 3'd0;
    end else begin
      busy_r <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_FINISH);
      done_r <= (state_nxt_s == S_FINISH);
      fail_r <= (state_nxt_s == S_FINISH) && fail_s;
      if ((state_r == S_RD_RSP) && data_bus.rvalid) readback_r <= data_bus.rdata;
      if (state_nxt_s == S_FINISH) attempts_r <= sat_attempts(attempt_cnt_r);
    end
  end

  assign data_bus.req   = req_r;
  assign data_bus.we    = we_r;
  assign data_bus.be    = be_r;
  assign data_bus.addr  = addr_r;
  assign data_bus.wdata = word_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign fail           = fail_r;
  assign readback       = readback_r;
  assign attempts       = attempts_r;

endmodule

// File: tb/tb_pmc_dc_init.sv
// Directed bench for pmc_dc_init: the bench plays the PMC config slave cycle by cycle.
module tb_pmc_dc_init;

  localparam logic [31:0] BASE = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] cfg_wdata;
  logic        busy, done, fail;
  logic [31:0] readback;
  logic [2:0]  attempts;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          t0 = 0;

  ibex_data_bus bus ();

  pmc_dc_init #(
    .BASE_ADDR      (BASE),
    .MAX_RETRIES    (3),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_bus  (bus.master),
    .start     (start),
    .cfg_wdata (cfg_wdata),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .readback  (readback),
    .attempts  (attempts)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the first request cycle; ends at the negedge after the response.
  task automatic serve(input string tag, input logic wr, input int gdly,
                       input logic [31:0] word, input logic [31:0] rdat, input logic e);
    for (int i = 0; i <= gdly; i++) begin
      chk({tag, " req"}, 32'(bus.req), 32'd1);
      chk({tag, " we"}, 32'(bus.we), 32'(wr));
      chk({tag, " be"}, 32'(bus.be), 32'hF);
      chk({tag, " addr"}, bus.addr, BASE);
      if (wr) chk({tag, " wdata"}, bus.wdata, word);
      if (i == gdly) bus.gnt = 1'b1;
      tick();
    end
    bus.gnt = 1'b0;
    chk({tag, " req drop"}, 32'(bus.req), 32'd0);
    bus.rvalid = 1'b1;
    bus.rdata  = rdat;
    bus.err    = e;
    tick();
    bus.rvalid = 1'b0;
    bus.rdata  = 32'h0;
    bus.err    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.err = 1'b0;
    start = 1'b0; cfg_wdata = 32'h0; rst_n = 1'b0;
    tick(); tick();
    chk("rst req", 32'(bus.req), 32'd0);
    chk("rst we", 32'(bus.we), 32'd0);
    chk("rst be", 32'(bus.be), 32'd0);
    chk("rst addr", bus.addr, 32'd0);
    chk("rst wdata", bus.wdata, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst fail", 32'(fail), 32'd0);
    chk("rst readback", readback, 32'd0);
    chk("rst attempts", 32'(attempts), 32'd0);
    rst_n = 1'b1;
    tick();

    // Happy path
    cfg_wdata = 32'h0000_0A5C; start = 1'b1; t0 = cyc;
    tick(); start = 1'b0;
    chk("happy busy", 32'(busy), 32'd1);
    serve("happy wr", 1'b1, 0, 32'h0000_0A5C, 32'h0, 1'b0);
    serve("happy rd", 1'b0, 0, 32'h0000_0A5C, 32'h0000_0A5C, 1'b0);
    chk("happy latency", 32'(cyc - t0), 32'd5);
    chk("happy done", 32'(done), 32'd1);
    chk("happy fail", 32'(fail), 32'd0);
    chk("happy busy end", 32'(busy), 32'd0);
    chk("happy attempts", 32'(attempts), 32'd1);
    chk("happy readback", readback, 32'h0000_0A5C);
    tick();
    chk("happy done pulse", 32'(done), 32'd0);

    // Delayed grant on the write
    cfg_wdata = 32'hCAFE_F00D; start = 1'b1;
    tick(); start = 1'b0;
    serve("dly wr", 1'b1, 10, 32'hCAFE_F00D, 32'h0, 1'b0);
    serve("dly rd", 1'b0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
    chk("dly done", 32'(done), 32'd1);
    chk("dly fail", 32'(fail), 32'd0);
    chk("dly attempts", 32'(attempts), 32'd1);
    tick();

    // Mismatch then recover
    cfg_wdata = 32'h1234_5678; start = 1'b1;
    tick(); start = 1'b0;
    serve("mis wr1", 1'b1, 0, 32'h1234_5678, 32'h0, 1'b0);
    serve("mis rd1", 1'b0, 0, 32'h1234_5678, 32'h0, 1'b0);
    chk("mis readback1", readback, 32'h0);
    chk("mis busy", 32'(busy), 32'd1);
    chk("mis no done", 32'(done), 32'd0);
    serve("mis wr2", 1'b1, 0, 32'h1234_5678, 32'h0, 1'b0);
    serve("mis rd2", 1'b0, 0, 32'h1234_5678, 32'h1234_5678, 1'b0);
    chk("mis done", 32'(done), 32'd1);
    chk("mis fail", 32'(fail), 32'd0);
    chk("mis attempts", 32'(attempts), 32'd2);
    chk("mis readback2", readback, 32'h1234_5678);
    tick();

    // Persistent write error: four writes, no reads
    cfg_wdata = 32'hDEAD_BEEF; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      serve("err wr", 1'b1, 0, 32'hDEAD_BEEF, 32'h0, 1'b1);
    end
    chk("err done", 32'(done), 32'd1);
    chk("err fail", 32'(fail), 32'd1);
    chk("err attempts", 32'(attempts), 32'd4);
    chk("err readback", readback, 32'h1234_5678);
    tick();
    chk("err fail pulse", 32'(fail), 32'd0);

    // Timeout with no grant; a start pulse while busy must be ignored
    cfg_wdata = 32'h5555_AAAA; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk("tmo req", 32'(bus.req), 32'd1);
      if (k == 5) begin
        start = 1'b1;
        cfg_wdata = 32'h0;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("tmo req low", 32'(bus.req), 32'd0);
    chk("tmo done", 32'(done), 32'd1);
    chk("tmo fail", 32'(fail), 32'd1);
    chk("tmo attempts", 32'(attempts), 32'd1);
    chk("tmo busy", 32'(busy), 32'd0);
    chk("tmo wdata kept", bus.wdata, 32'h5555_AAAA);
    // Start in the finish cycle is ignored
    start = 1'b1; cfg_wdata = 32'h1111_1111;
    tick(); start = 1'b0;
    chk("fin start busy", 32'(busy), 32'd0);
    chk("fin start req", 32'(bus.req), 32'd0);
    tick();
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle req", 32'(bus.req), 32'd0);

    // Async reset while waiting for the read response
    cfg_wdata = 32'h0F0F_0F0F; start = 1'b1;
    tick(); start = 1'b0;
    serve("rst wr", 1'b1, 0, 32'h0F0F_0F0F, 32'h0, 1'b0);
    chk("rst rd req", 32'(bus.req), 32'd1);
    chk("rst rd we", 32'(bus.we), 32'd0);
    bus.gnt = 1'b1;
    tick(); bus.gnt = 1'b0;
    chk("rst rsp busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst req", 32'(bus.req), 32'd0);
    chk("arst be", 32'(bus.be), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst readback", readback, 32'd0);
    chk("arst attempts", 32'(attempts), 32'd0);
    chk("arst wdata", bus.wdata, 32'd0);
    chk("arst addr", bus.addr, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.rvalid = 1'b1; bus.rdata = 32'h0F0F_0F0F;
    tick();
    bus.rvalid = 1'b0; bus.rdata = 32'h0;
    chk("stray readback", readback, 32'd0);
    chk("stray busy", 32'(busy), 32'd0);
    chk("stray req", 32'(bus.req), 32'd0);
    chk("stray done", 32'(done), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
